crack_scheduler: RTL

Dynamic work scheduler for the password-cracker worker array. It replaces the fixed per-instance character ranges with on-demand dispatch. The first-character index space is split into CHUNK-sized ranges, and each range is handed to the next idle worker in round-robin order. The block stops every worker as soon as any one reports a match, and reports a single found/done result upward to the cracker top level.

---
 rtl/crack_scheduler_if.sv | 26 ++
 rtl/crack_scheduler.sv | 99 +++++++++
 2 files changed

// File: rtl/crack_scheduler_if.sv
// crack_scheduler_if: dispatch and result bundle between the scheduler and the worker array
interface crack_scheduler_if #(
  parameter int NUM_WORKERS = 4,
  parameter int IDXW = 6,
  parameter int WIDW = 2
);
  logic start;
  logic [NUM_WORKERS-1:0] wkr_done;
  logic [NUM_WORKERS-1:0] wkr_found;
  logic [NUM_WORKERS-1:0] wkr_start;
  logic [IDXW-1:0] wkr_from;
  logic [IDXW-1:0] wkr_to;
  logic wkr_abort;
  logic busy;
  logic found;
  logic [WIDW-1:0] found_worker;
  logic done;
  modport master (
    input start, wkr_done, wkr_found,
    output wkr_start, wkr_from, wkr_to, wkr_abort, busy, found, found_worker, done
  );
  modport slave (
    output start, wkr_done, wkr_found,
    input wkr_start, wkr_from, wkr_to, wkr_abort, busy, found, found_worker, done
  );
endinterface

// File: rtl/crack_scheduler.sv
// crack_scheduler: round-robin chunk dispatcher for the cracker workers with abort on first match
module crack_scheduler #(
  parameter int NUM_WORKERS = 4,
  parameter int CHARSET = 36,
  parameter int CHUNK = 4,
  parameter int IDXW = 6,
  parameter int WIDW = 2
) (
  input logic clk,
  input logic rst,
  crack_scheduler_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
  localparam logic [IDXW:0] LAST = (IDXW+1)'(CHARSET - 1);
  state_t state;
  logic [NUM_WORKERS-1:0] assigned, remain, hit, gvec;
  logic [IDXW:0] next_idx, nxt, top_raw, top;
  logic [WIDW-1:0] rr_ptr, gnt, lo, hi, fw;
  logic gnt_ok, hi_ok;
  assign hit = bus.wkr_found & assigned;
  assign remain = assigned & ~bus.wkr_done;
  assign nxt = next_idx + (IDXW+1)'(CHUNK);
  assign top_raw = nxt - 1'b1;
  assign top = top_raw > LAST ? LAST : top_raw;
  always_comb begin
    gnt_ok = 1'b0;
    hi_ok = 1'b0;
    lo = '0;
    hi = '0;
    fw = '0;
    for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
      if (!assigned[i]) begin
        gnt_ok = 1'b1;
        lo = WIDW'(i);
        if (WIDW'(i) >= rr_ptr) begin
          hi_ok = 1'b1;
          hi = WIDW'(i);
        end
      end
      if (hit[i]) fw = WIDW'(i);
    end
  end
  assign gnt = hi_ok ? hi : lo;
  assign gvec = NUM_WORKERS'(1) << gnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      assigned <= '0;
      next_idx <= '0;
      rr_ptr <= '0;
      bus.wkr_start <= '0;
      bus.wkr_from <= '0;
      bus.wkr_to <= '0;
      bus.wkr_abort <= 1'b0;
      bus.busy <= 1'b0;
      bus.found <= 1'b0;
      bus.found_worker <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.wkr_start <= '0;
      bus.wkr_abort <= 1'b0;
      case (state)
        IDLE, FINISH: if (bus.start) begin
          bus.found <= 1'b0;
          bus.done <= 1'b0;
          bus.busy <= 1'b1;
          assigned <= '0;
          next_idx <= '0;
          rr_ptr <= '0;
          state <= RUN;
        end
        default: begin
          assigned <= remain;
          if (|hit) begin
            bus.found <= 1'b1;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            bus.found_worker <= fw;
            bus.wkr_abort <= 1'b1;
            assigned <= '0;
            state <= FINISH;
          end else if (state == RUN && gnt_ok) begin
            bus.wkr_start <= gvec;
            bus.wkr_from <= next_idx[IDXW-1:0];
            bus.wkr_to <= top[IDXW-1:0];
            assigned <= remain | gvec;
            rr_ptr <= gnt == WIDW'(NUM_WORKERS - 1) ? '0 : gnt + 1'b1;
            next_idx <= nxt;
            if (nxt >= (IDXW+1)'(CHARSET)) state <= DRAIN;
          end else if (state == DRAIN && remain == '0) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state <= FINISH;
          end
        end
      endcase
    end
  end
endmodule
